// File: rtl/bus_arbiter_rr_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr_pkg
//   Shared types and helpers for the round-robin split-capable bus arbiter.
//   - arb_state_e   : arbiter FSM states
//   - MAX_MASTERS   : largest supported master count (one-hot helper width)
//   - onehot_to_idx : one-hot grant vector to binary owner index
// -----------------------------------------------------------------------------
package bus_arbiter_rr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANTED,
        BUSY
    } arb_state_e;

    localparam int unsigned MAX_MASTERS = 8;
    localparam int unsigned IDX_W       = 3;

    // OR-reduction of set bit positions; returns 0 for an all-zero vector.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr_if
//   Request/grant/split handshake between the bus masters, the address
//   decoder, the slaves and the arbiter.
//   B_REQ        per-master request (level)
//   B_GRANT      one-hot grant from the arbiter
//   BUS_OWNER    binary index of the granted master
//   B_UTIL       granted master has started driving the bus
//   B_SBSY       slave busy flags
//   SPL_SEL      decoder: current transfer targets the split-capable slave
//   B_DONE       transfer complete pulse
//   B_SPLIT      owner is being split off the bus
//   B_SPL_RESUME split master re-granted to finish
//   modport slave  : arbiter side
//   modport master : bus-fabric side (masters, decoder, slaves)
// -----------------------------------------------------------------------------
interface bus_arbiter_rr_if #(
    parameter int unsigned N_MASTERS = 4,
    parameter int unsigned N_SLAVES  = 3
);
    localparam int unsigned OWNER_W = $clog2(N_MASTERS);

    logic [N_MASTERS-1:0] B_REQ;
    logic [N_MASTERS-1:0] B_GRANT;
    logic [OWNER_W-1:0]   BUS_OWNER;
    logic                 B_UTIL;
    logic [N_SLAVES-1:0]  B_SBSY;
    logic                 SPL_SEL;
    logic                 B_DONE;
    logic                 B_SPLIT;
    logic                 B_SPL_RESUME;

    modport slave (
        input  B_REQ, B_UTIL, B_SBSY, SPL_SEL, B_DONE,
        output B_GRANT, BUS_OWNER, B_SPLIT, B_SPL_RESUME
    );

    modport master (
        output B_REQ, B_UTIL, B_SBSY, SPL_SEL, B_DONE,
        input  B_GRANT, BUS_OWNER, B_SPLIT, B_SPL_RESUME
    );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin selector: first set bit of (req & mask)
//   at or after ptr, wrapping past N_MASTERS-1 to 0.
//   req   in  N_MASTERS  raw requests
//   mask  in  N_MASTERS  eligibility mask
//   ptr   in  OWNER_W    highest-priority position this round
//   valid out 1          some eligible request exists
//   idx   out OWNER_W    index of the selected master
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int unsigned N_MASTERS = 4
) (
    input  logic [N_MASTERS-1:0]         req,
    input  logic [N_MASTERS-1:0]         mask,
    input  logic [$clog2(N_MASTERS)-1:0] ptr,
    output logic                         valid,
    output logic [$clog2(N_MASTERS)-1:0] idx
);
    localparam int unsigned OWNER_W = $clog2(N_MASTERS);

    logic [N_MASTERS-1:0] cand;
    int unsigned          pos;

    always_comb begin
        cand  = req & mask;
        valid = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int unsigned k = 0; k < N_MASTERS; k++) begin
            pos = (32'(ptr) + k) % N_MASTERS;
            if (!valid && cand[pos]) begin
                valid = 1'b1;
                idx   = OWNER_W'(pos);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr
//   Round-robin bus arbiter for N masters with one outstanding split
//   transaction on a single split-capable slave and an idle-grant timeout.
//   CLK   in  1  rising-edge clock
//   RSTN  in  1  asynchronous active-low reset
//   bus   slave modport of bus_arbiter_rr_if (requests, grant, owner,
//         utilisation, slave busy, split select, done, split/resume pulses)
// -----------------------------------------------------------------------------
module bus_arbiter_rr
    import bus_arbiter_rr_pkg::*;
#(
    parameter int unsigned N_MASTERS   = 4,
    parameter int unsigned N_SLAVES    = 3,
    parameter int unsigned SPLIT_SLAVE = 2,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic            CLK,
    input  logic            RSTN,
    bus_arbiter_rr_if.slave bus
);
    localparam int unsigned OWNER_W = $clog2(N_MASTERS);
    localparam int unsigned TIMER_W = $clog2(TIMEOUT);

    arb_state_e           state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic                 split_q, split_d;
    logic                 resume_q, resume_d;
    logic                 split_pend_q, split_pend_d;
    logic [OWNER_W-1:0]   split_owner_q, split_owner_d;
    logic [OWNER_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;

    logic [MAX_MASTERS-1:0] grant_pad;
    logic [IDX_W-1:0]       owner_full;
    logic [OWNER_W-1:0]     owner;
    logic [OWNER_W-1:0]     owner_next;
    logic [N_MASTERS-1:0]   elig_mask;
    logic                   pick_valid;
    logic [OWNER_W-1:0]     pick_idx;
    logic                   spl_busy;
    logic                   unused_ok;

    // Owner is derived from the registered grant so the two cannot disagree.
    always_comb begin
        grant_pad                 = '0;
        grant_pad[N_MASTERS-1:0]  = grant_q;
    end
    assign owner_full = onehot_to_idx(grant_pad);
    assign owner      = owner_full[OWNER_W-1:0];
    assign owner_next = (owner == OWNER_W'(N_MASTERS - 1)) ? '0 : owner + 1'b1;
    assign spl_busy   = bus.B_SBSY[SPLIT_SLAVE];
    assign unused_ok  = ^{bus.B_SBSY, owner_full};

    // The split-off master may not win a fresh grant until it is resumed.
    always_comb begin
        elig_mask = '1;
        if (split_pend_q) begin
            elig_mask[split_owner_q] = 1'b0;
        end
    end

    rr_picker #(.N_MASTERS(N_MASTERS)) u_picker (
        .req   (bus.B_REQ),
        .mask  (elig_mask),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        split_d       = 1'b0;
        resume_d      = 1'b0;
        split_pend_d  = split_pend_q;
        split_owner_d = split_owner_q;
        rr_ptr_d      = rr_ptr_q;
        timer_d       = timer_q;

        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                if (split_pend_q && !spl_busy) begin
                    grant_d[split_owner_q] = 1'b1;
                    resume_d               = 1'b1;
                    split_pend_d           = 1'b0;
                    state_d                = BUSY;
                end else if (pick_valid) begin
                    grant_d[pick_idx] = 1'b1;
                    timer_d           = '0;
                    state_d           = GRANTED;
                end
            end
            GRANTED: begin
                if (bus.B_UTIL) begin
                    state_d = BUSY;
                end else if (!bus.B_REQ[owner]) begin
                    grant_d = '0;
                    state_d = IDLE;
                end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                    grant_d  = '0;
                    rr_ptr_d = owner_next;
                    state_d  = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            BUSY: begin
                // Completion outranks a split request seen in the same cycle.
                if (bus.B_DONE) begin
                    grant_d  = '0;
                    rr_ptr_d = owner_next;
                    state_d  = IDLE;
                end else if (bus.SPL_SEL && spl_busy && !split_pend_q) begin
                    split_d       = 1'b1;
                    split_owner_d = owner;
                    split_pend_d  = 1'b1;
                    grant_d       = '0;
                    rr_ptr_d      = owner_next;
                    state_d       = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            split_q       <= 1'b0;
            resume_q      <= 1'b0;
            split_pend_q  <= 1'b0;
            split_owner_q <= '0;
            rr_ptr_q      <= '0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            split_q       <= split_d;
            resume_q      <= resume_d;
            split_pend_q  <= split_pend_d;
            split_owner_q <= split_owner_d;
            rr_ptr_q      <= rr_ptr_d;
            timer_q       <= timer_d;
        end
    end

    assign bus.B_GRANT      = grant_q;
    assign bus.BUS_OWNER    = owner;
    assign bus.B_SPLIT      = split_q;
    assign bus.B_SPL_RESUME = resume_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_rr
//   Self-checking bench for bus_arbiter_rr (4 masters, 3 slaves, split slave
//   2, timeout 16). Table rows hold one cycle of inputs and the outputs
//   expected after the following clock edge.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_rr;

    localparam int unsigned NM = 4;
    localparam int unsigned NS = 3;

    typedef struct {
        logic [3:0] req;
        logic       util;
        logic [2:0] sbsy;
        logic       sel;
        logic       done;
        logic [3:0] eg;
        logic       es;
        logic       er;
    } vec_t;

    typedef struct {
        logic [3:0] g;
        logic       s;
        logic       r;
    } exp_t;

    logic CLK  = 1'b0;
    logic RSTN = 1'b0;
    always #5 CLK = ~CLK;

    bus_arbiter_rr_if #(.N_MASTERS(NM), .N_SLAVES(NS)) arb_bus ();

    bus_arbiter_rr #(
        .N_MASTERS   (NM),
        .N_SLAVES    (NS),
        .SPLIT_SLAVE (2),
        .TIMEOUT     (16)
    ) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (arb_bus)
    );

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [1:0] idx_of(input logic [3:0] oh);
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) r = 2'(i);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic add(input logic [3:0] req, input logic util, input logic [2:0] sbsy,
                       input logic sel, input logic done, input logic [3:0] eg,
                       input logic es, input logic er);
        vec_t v;
        v.req = req; v.util = util; v.sbsy = sbsy; v.sel = sel; v.done = done;
        v.eg = eg; v.es = es; v.er = er;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        arb_bus.B_REQ   = v.req;
        arb_bus.B_UTIL  = v.util;
        arb_bus.B_SBSY  = v.sbsy;
        arb_bus.SPL_SEL = v.sel;
        arb_bus.B_DONE  = v.done;
        e.g = v.eg; e.s = v.es; e.r = v.er;
        sb.push_back(e);
    endtask

    task automatic step_check(input string tag);
        exp_t e;
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".scoreboard"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, ".grant"}, 32'(arb_bus.B_GRANT), 32'(e.g));
            if (e.g != 4'b0000) chk({tag, ".owner"}, 32'(arb_bus.BUS_OWNER), 32'(idx_of(e.g)));
            chk({tag, ".split"}, 32'(arb_bus.B_SPLIT), 32'(e.s));
            chk({tag, ".resume"}, 32'(arb_bus.B_SPL_RESUME), 32'(e.r));
        end
    endtask

    task automatic run(input string tag, input logic [3:0] req, input logic util,
                       input logic [2:0] sbsy, input logic sel, input logic done,
                       input logic [3:0] eg, input logic es, input logic er);
        vec_t v;
        v.req = req; v.util = util; v.sbsy = sbsy; v.sel = sel; v.done = done;
        v.eg = eg; v.es = es; v.er = er;
        drive(v);
        step_check(tag);
    endtask

    initial begin
        // Round robin over four always-requesting masters.
        add(4'b1111, 0, 3'b000, 0, 0, 4'b0001, 0, 0);
        add(4'b1111, 1, 3'b000, 0, 0, 4'b0001, 0, 0);
        add(4'b1111, 0, 3'b000, 0, 1, 4'b0000, 0, 0);
        add(4'b1111, 0, 3'b000, 0, 0, 4'b0010, 0, 0);
        add(4'b1111, 1, 3'b000, 0, 0, 4'b0010, 0, 0);
        add(4'b1111, 0, 3'b000, 0, 1, 4'b0000, 0, 0);
        add(4'b1111, 0, 3'b000, 0, 0, 4'b0100, 0, 0);
        add(4'b1111, 1, 3'b000, 0, 0, 4'b0100, 0, 0);
        add(4'b1111, 0, 3'b000, 0, 1, 4'b0000, 0, 0);
        add(4'b1111, 0, 3'b000, 0, 0, 4'b1000, 0, 0);
        add(4'b1111, 1, 3'b000, 0, 0, 4'b1000, 0, 0);
        add(4'b1111, 0, 3'b000, 0, 1, 4'b0000, 0, 0);
        add(4'b1111, 0, 3'b000, 0, 0, 4'b0001, 0, 0);
        add(4'b1111, 1, 3'b000, 0, 0, 4'b0001, 0, 0);
        add(4'b1111, 0, 3'b000, 0, 1, 4'b0000, 0, 0);
        add(4'b0000, 0, 3'b000, 0, 0, 4'b0000, 0, 0);
        // Split of M1, M2 served meanwhile, then M1 resumed.
        add(4'b0110, 0, 3'b100, 0, 0, 4'b0010, 0, 0);
        add(4'b0110, 1, 3'b100, 0, 0, 4'b0010, 0, 0);
        add(4'b0110, 0, 3'b100, 1, 0, 4'b0000, 1, 0);
        add(4'b0110, 0, 3'b100, 0, 0, 4'b0100, 0, 0);
        add(4'b0110, 1, 3'b100, 0, 0, 4'b0100, 0, 0);
        add(4'b0110, 0, 3'b000, 0, 0, 4'b0100, 0, 0);
        add(4'b0110, 0, 3'b000, 0, 1, 4'b0000, 0, 0);
        add(4'b0010, 0, 3'b000, 0, 0, 4'b0010, 0, 1);
        add(4'b0010, 0, 3'b000, 0, 1, 4'b0000, 0, 0);
        add(4'b0000, 0, 3'b000, 0, 0, 4'b0000, 0, 0);
        // Idle-grant timeout on M3, then M0 next.
        add(4'b1001, 0, 3'b000, 0, 0, 4'b1000, 0, 0);
        for (int i = 0; i < 15; i++) add(4'b1001, 0, 3'b000, 0, 0, 4'b1000, 0, 0);
        add(4'b1001, 0, 3'b000, 0, 0, 4'b0000, 0, 0);
        add(4'b1001, 0, 3'b000, 0, 0, 4'b0001, 0, 0);
        add(4'b1001, 1, 3'b000, 0, 0, 4'b0001, 0, 0);
        // Done and split request together: done wins, nothing left pending.
        add(4'b1001, 0, 3'b100, 1, 1, 4'b0000, 0, 0);
        add(4'b0001, 0, 3'b100, 0, 0, 4'b0001, 0, 0);
        add(4'b0001, 1, 3'b100, 0, 0, 4'b0001, 0, 0);
        // M0 split; M2 hits the busy split slave again: no second split.
        add(4'b0001, 0, 3'b100, 1, 0, 4'b0000, 1, 0);
        add(4'b0101, 0, 3'b100, 0, 0, 4'b0100, 0, 0);
        add(4'b0101, 1, 3'b100, 0, 0, 4'b0100, 0, 0);
        add(4'b0101, 0, 3'b100, 1, 0, 4'b0100, 0, 0);
        add(4'b0101, 0, 3'b100, 1, 0, 4'b0100, 0, 0);
        add(4'b0101, 0, 3'b100, 1, 1, 4'b0000, 0, 0);
        add(4'b0001, 0, 3'b100, 0, 0, 4'b0000, 0, 0);

        // Reset held with all masters requesting.
        arb_bus.B_REQ   = 4'b1111;
        arb_bus.B_UTIL  = 1'b0;
        arb_bus.B_SBSY  = 3'b000;
        arb_bus.SPL_SEL = 1'b0;
        arb_bus.B_DONE  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset.grant",  32'(arb_bus.B_GRANT), 32'd0);
        chk("reset.owner",  32'(arb_bus.BUS_OWNER), 32'd0);
        chk("reset.split",  32'(arb_bus.B_SPLIT), 32'd0);
        chk("reset.resume", 32'(arb_bus.B_SPL_RESUME), 32'd0);
        RSTN = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            step_check($sformatf("v%0d", i));
        end

        // Reset while M1 is busy and M0's split is still pending.
        run("mr.grant1", 4'b0011, 0, 3'b100, 0, 0, 4'b0010, 0, 0);
        run("mr.busy1",  4'b0011, 1, 3'b100, 0, 0, 4'b0010, 0, 0);
        RSTN = 1'b0;
        #1;
        chk("mr.async_grant",  32'(arb_bus.B_GRANT), 32'd0);
        chk("mr.async_split",  32'(arb_bus.B_SPLIT), 32'd0);
        chk("mr.async_resume", 32'(arb_bus.B_SPL_RESUME), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        chk("mr.held_grant", 32'(arb_bus.B_GRANT), 32'd0);
        RSTN = 1'b1;
        run("mr.idle0",  4'b0000, 0, 3'b000, 0, 0, 4'b0000, 0, 0);
        run("mr.idle1",  4'b0000, 0, 3'b000, 0, 0, 4'b0000, 0, 0);
        run("mr.fresh",  4'b0001, 0, 3'b000, 0, 0, 4'b0001, 0, 0);
        run("mr.util",   4'b0001, 1, 3'b000, 0, 0, 4'b0001, 0, 0);
        run("mr.done",   4'b0001, 0, 3'b000, 0, 1, 4'b0000, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
